// File: rtl/ram_dma_engine_if.sv
// Purpose: RAM port bundle between the DMA engine (master) and one dual-port RAM port (slave).
// Latency: pure wiring; read data is expected one cycle after a read is issued.
// Backpressure: none; the RAM accepts one access per enabled cycle.
// Signals: en (port enable), we (byte write enables), addr (word address),
//          din (write data towards RAM), dout (read data from RAM).
interface ram_dma_engine_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 32
);
    logic                  en;
    logic [DATA_W/8-1:0]   we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     din;
    logic [DATA_W-1:0]     dout;

    modport master (
        output en,
        output we,
        output addr,
        output din,
        input  dout
    );

    modport slave (
        input  en,
        input  we,
        input  addr,
        input  din,
        output dout
    );
endinterface

// File: rtl/ram_dma_engine.sv
// Purpose: copy or fill blocks of words in a RAM through a single byte-write-enabled port.
// Latency: copy takes 3 cycles per word, fill 1 cycle per word, plus one DONE cycle.
// Backpressure: none; start is only sampled in IDLE, abort ends the command early.
// Ports: clk/rst_n; command in (start, mode, src_addr, dst_addr, len, fill_data, byte_en, abort);
//        status out (busy, done, aborted, xfer_count); ram (master side of the RAM port bundle).
module ram_dma_engine #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                mode,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [LEN_W-1:0]    len,
    input  logic [DATA_W-1:0]   fill_data,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [LEN_W-1:0]    xfer_count,
    ram_dma_engine_if.master    ram
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              mode_r;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [LEN_W-1:0]  len_r;
    logic [DATA_W-1:0] fill_r;
    logic [BE_W-1:0]   be_r;
    logic [DATA_W-1:0] hold_r;
    logic [LEN_W-1:0]  count_r;
    logic              aborted_r;

    logic [LEN_W-1:0]  count_inc;
    logic              last_write;

    assign count_inc  = count_r + LEN_W'(1);
    assign last_write = (count_inc == len_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_nxt = S_DONE;
                    end else if (mode) begin
                        state_nxt = S_WRITE;
                    end else begin
                        state_nxt = S_READ;
                    end
                end
            end
            S_READ:    state_nxt = abort ? S_DONE : S_CAPTURE;
            S_CAPTURE: state_nxt = abort ? S_DONE : S_WRITE;
            S_WRITE: begin
                // The write in this cycle always lands; abort only stops what follows.
                if (abort || last_write) begin
                    state_nxt = S_DONE;
                end else if (mode_r) begin
                    state_nxt = S_WRITE;
                end else begin
                    state_nxt = S_READ;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r    <= 1'b0;
            src_r     <= '0;
            dst_r     <= '0;
            len_r     <= '0;
            fill_r    <= '0;
            be_r      <= '0;
            hold_r    <= '0;
            count_r   <= '0;
            aborted_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_r    <= mode;
                        src_r     <= src_addr;
                        dst_r     <= dst_addr;
                        len_r     <= len;
                        fill_r    <= fill_data;
                        be_r      <= byte_en;
                        count_r   <= '0;
                        aborted_r <= 1'b0;
                    end
                end
                S_READ: begin
                    if (abort) begin
                        aborted_r <= 1'b1;
                    end
                end
                S_CAPTURE: begin
                    // On abort the captured word is simply never written.
                    hold_r <= ram.dout;
                    if (abort) begin
                        aborted_r <= 1'b1;
                    end
                end
                S_WRITE: begin
                    count_r <= count_inc;
                    src_r   <= src_r + ADDR_W'(1);
                    dst_r   <= dst_r + ADDR_W'(1);
                    if (abort) begin
                        aborted_r <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // RAM port is decoded from registered state and registers only, so no
    // input can reach the RAM combinationally.
    always_comb begin
        ram.en   = 1'b0;
        ram.we   = '0;
        ram.addr = '0;
        ram.din  = '0;
        case (state)
            S_READ: begin
                ram.en   = 1'b1;
                ram.addr = src_r;
            end
            S_WRITE: begin
                ram.en   = 1'b1;
                ram.we   = be_r;
                ram.addr = dst_r;
                ram.din  = mode_r ? fill_r : hold_r;
            end
            default: begin
            end
        endcase
    end

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign aborted    = aborted_r;
    assign xfer_count = count_r;

endmodule

// File: tb/tb_ram_dma_engine.sv
module tb_ram_dma_engine;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 20;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] fill_data;
    logic [3:0]        byte_en;
    logic              abort;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [LEN_W-1:0]  xfer_count;

    int checks = 0;
    int errors = 0;
    int prev_count = 0;
    logic prev_aborted = 1'b0;

    always #5 clk = ~clk;

    ram_dma_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram_bus ();

    ram_dma_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .fill_data  (fill_data),
        .byte_en    (byte_en),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .xfer_count (xfer_count),
        .ram        (ram_bus)
    );

    typedef struct {
        int          cyc;
        logic [18:0] addr;
        logic [3:0]  we;
        logic [31:0] din;
        logic        chk;
    } acc_t;

    // Sparse RAM seen by the DUT, and the reference image the model maintains.
    logic [31:0] mem     [logic [18:0]];
    logic [31:0] ref_mem [logic [18:0]];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [18:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [18:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic preload(input logic [18:0] a, input logic [31:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    // RAM port model: read-first, registered read data.
    always @(posedge clk) begin : ram_model
        logic [31:0] cur;
        if (ram_bus.en === 1'b1) begin
            cur = mem_rd(ram_bus.addr);
            ram_bus.dout <= cur;
            if (ram_bus.we != 4'h0) begin
                mem[ram_bus.addr] = merge(cur, ram_bus.din, ram_bus.we);
            end
        end
    end

    // Issues one command at the next falling edge and follows it to done.
    // abort_cyc / bs_cyc: cycle (0 = start cycle) at which abort / a stray start is driven, -1 for none.
    task automatic run_cmd(input string name, input logic m, input logic [18:0] s, input logic [18:0] d,
                           input int n, input logic [31:0] f, input logic [3:0] be,
                           input int abort_cyc, input int bs_cyc);
        acc_t expq[$];
        acc_t obsq[$];
        acc_t a;
        int natural, dcyc, last, nw, rc, wc;
        logic exp_ab, done_seen;
        logic [18:0] sa, da;
        logic [31:0] val;

        natural = (n == 0) ? 1 : (m ? n + 1 : 3 * n + 1);
        dcyc = natural;
        exp_ab = 1'b0;
        if (abort_cyc >= 1 && abort_cyc < natural) begin
            dcyc = abort_cyc + 1;
            exp_ab = 1'b1;
        end
        last = dcyc - 1;
        nw = 0;
        for (int k = 0; k < n; k++) begin
            sa = s + 19'(k);
            da = d + 19'(k);
            if (!m) begin
                rc = 3 * k + 1;
                wc = 3 * k + 3;
                if (rc <= last) begin
                    a = '{rc, sa, 4'h0, 32'h0, 1'b0};
                    expq.push_back(a);
                end
                val = ref_rd(sa);
            end else begin
                wc = k + 1;
                val = f;
            end
            if (wc <= last) begin
                a = '{wc, da, be, val, 1'b1};
                expq.push_back(a);
                ref_mem[da] = merge(ref_rd(da), val, be);
                nw++;
            end
        end

        done_seen = 1'b0;
        for (int c = 0; c <= dcyc + 8 && !done_seen; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s idle_status: busy=%b done=%b, expected 0/0", name, busy, done);
                end
                checks++;
                if (xfer_count !== LEN_W'(prev_count) || aborted !== prev_aborted) begin
                    errors++;
                    $display("FAIL %s held_status: count=%0d aborted=%b, expected %0d/%b",
                             name, xfer_count, aborted, prev_count, prev_aborted);
                end
            end else if (c <= dcyc) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy cycle %0d: got %b expected 1", name, c, busy);
                end
            end
            if (ram_bus.en === 1'b1) begin
                a = '{c, ram_bus.addr, ram_bus.we, ram_bus.din, 1'b0};
                obsq.push_back(a);
            end
            if (done === 1'b1) begin
                done_seen = 1'b1;
                checks++;
                if (c != dcyc) begin
                    errors++;
                    $display("FAIL %s done_cycle: got %0d expected %0d", name, c, dcyc);
                end
                checks++;
                if (aborted !== exp_ab || xfer_count !== LEN_W'(nw)) begin
                    errors++;
                    $display("FAIL %s final_status: aborted=%b count=%0d, expected %b/%0d",
                             name, aborted, xfer_count, exp_ab, nw);
                end
            end
            start = (c == 0) || (c == bs_cyc);
            abort = (c == abort_cyc);
            if (c == 0) begin
                mode = m; src_addr = s; dst_addr = d; len = LEN_W'(n);
                fill_data = f; byte_en = be;
            end else begin
                mode = 1'($urandom); src_addr = 19'($urandom); dst_addr = 19'($urandom);
                len = LEN_W'($urandom); fill_data = $urandom; byte_en = 4'($urandom);
            end
        end
        start = 1'b0;
        abort = 1'b0;

        if (!done_seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no done within %0d cycles, expected done at %0d", name, dcyc + 8, dcyc);
        end

        checks++;
        if (obsq.size() != expq.size()) begin
            errors++;
            $display("FAIL %s access_count: got %0d expected %0d", name, obsq.size(), expq.size());
        end
        for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
            checks++;
            if (obsq[i].cyc != expq[i].cyc || obsq[i].addr !== expq[i].addr || obsq[i].we !== expq[i].we ||
                (expq[i].chk && obsq[i].din !== expq[i].din)) begin
                errors++;
                $display("FAIL %s access %0d: got cyc=%0d addr=%h we=%h din=%h expected cyc=%0d addr=%h we=%h din=%h",
                         name, i, obsq[i].cyc, obsq[i].addr, obsq[i].we, obsq[i].din,
                         expq[i].cyc, expq[i].addr, expq[i].we, expq[i].din);
            end
        end
        foreach (expq[i]) begin
            if (expq[i].chk) begin
                checks++;
                if (mem_rd(expq[i].addr) !== ref_rd(expq[i].addr)) begin
                    errors++;
                    $display("FAIL %s ram[%h]: got %h expected %h", name, expq[i].addr,
                             mem_rd(expq[i].addr), ref_rd(expq[i].addr));
                end
            end
        end
        prev_count   = nw;
        prev_aborted = exp_ab;
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 || xfer_count !== '0 ||
            ram_bus.en !== 1'b0 || ram_bus.we !== 4'h0 || ram_bus.addr !== '0 || ram_bus.din !== '0) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b aborted=%b count=%0d en=%b we=%h addr=%h din=%h, expected all 0",
                     name, busy, done, aborted, xfer_count, ram_bus.en, ram_bus.we, ram_bus.addr, ram_bus.din);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        len = '0; fill_data = '0; byte_en = '0; abort = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset_values");
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("after_reset_release");
    endtask

    task automatic test_copy();
        for (int i = 0; i < 4; i++) preload(19'h100 + 19'(i), 32'hA000_0000 | 32'(i) | ($urandom & 32'h00FF_FF00));
        run_cmd("copy4", 1'b0, 19'h100, 19'h200, 4, $urandom, 4'hF, -1, -1);
    endtask

    task automatic test_fill_mask();
        for (int i = 0; i < 8; i++) preload(19'h10 + 19'(i), 32'h0);
        run_cmd("fill_mask", 1'b1, 19'h0, 19'h10, 8, 32'hDEADBEEF, 4'h3, -1, -1);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem_rd(19'h10 + 19'(i)) !== 32'h0000BEEF) begin
                errors++;
                $display("FAIL fill_mask word %0d: got %h expected 0000beef", i, mem_rd(19'h10 + 19'(i)));
            end
        end
    endtask

    task automatic test_wrap();
        logic [18:0] wa[4];
        wa[0] = 19'h7FFFE; wa[1] = 19'h7FFFF; wa[2] = 19'h00000; wa[3] = 19'h00001;
        preload(19'h7FFFD, 32'h0);
        preload(19'h00002, 32'h0);
        run_cmd("wrap", 1'b1, 19'h0, 19'h7FFFE, 4, 32'h5A5A_1234, 4'hF, -1, -1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_rd(wa[i]) !== 32'h5A5A_1234) begin
                errors++;
                $display("FAIL wrap ram[%h]: got %h expected 5a5a1234", wa[i], mem_rd(wa[i]));
            end
        end
        checks++;
        if (mem_rd(19'h7FFFD) !== 32'h0 || mem_rd(19'h00002) !== 32'h0) begin
            errors++;
            $display("FAIL wrap neighbours: got %h/%h expected 0/0", mem_rd(19'h7FFFD), mem_rd(19'h00002));
        end
    endtask

    task automatic test_len_zero();
        run_cmd("len0_copy", 1'b0, 19'h100, 19'h300, 0, $urandom, 4'hF, -1, -1);
        run_cmd("len0_fill", 1'b1, 19'h100, 19'h300, 0, $urandom, 4'hF, -1, -1);
    endtask

    task automatic test_abort();
        for (int i = 0; i < 10; i++) begin
            preload(19'h400 + 19'(i), $urandom);
            preload(19'h500 + 19'(i), 32'hC0FF_EE00);
        end
        // Capture cycle of word 3 is cycle 11.
        run_cmd("abort_capture", 1'b0, 19'h400, 19'h500, 10, 32'h0, 4'hF, 11, -1);
        checks++;
        if (mem_rd(19'h503) !== 32'hC0FF_EE00) begin
            errors++;
            $display("FAIL abort_capture no_4th_write: got %h expected c0ffee00", mem_rd(19'h503));
        end
        // Final write of a 3-word copy is cycle 9.
        run_cmd("abort_last_write", 1'b0, 19'h400, 19'h600, 3, 32'h0, 4'hF, 9, -1);
        run_cmd("abort_fill", 1'b1, 19'h0, 19'h700, 6, 32'h1111_2222, 4'hC, 3, -1);
        run_cmd("abort_read", 1'b0, 19'h400, 19'h680, 5, 32'h0, 4'hF, 4, -1);
        run_cmd("abort_idle", 1'b1, 19'h0, 19'h780, 3, 32'h3333_4444, 4'hF, 0, -1);
    endtask

    task automatic test_busy_start();
        for (int i = 0; i < 5; i++) preload(19'h800 + 19'(i), $urandom);
        run_cmd("busy_start", 1'b0, 19'h800, 19'h900, 5, 32'h0, 4'hF, -1, 4);
    endtask

    task automatic test_back_to_back();
        run_cmd("b2b_a", 1'b1, 19'h0, 19'hA00, 3, 32'hAAAA_5555, 4'h0, -1, -1);
        run_cmd("b2b_b", 1'b0, 19'h800, 19'hA10, 2, 32'h0, 4'h9, -1, -1);
        run_cmd("b2b_c", 1'b1, 19'h0, 19'hA20, 1, 32'h1234_5678, 4'hF, -1, -1);
    endtask

    task automatic test_reset_mid_copy();
        logic [31:0] w0;
        for (int i = 0; i < 6; i++) begin
            preload(19'h300 + 19'(i), $urandom);
            preload(19'h380 + 19'(i), 32'h0);
        end
        w0 = ref_rd(19'h300);
        @(negedge clk);
        start = 1'b1; mode = 1'b0; src_addr = 19'h300; dst_addr = 19'h380;
        len = LEN_W'(6); byte_en = 4'hF; abort = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            src_addr = 19'($urandom);
        end
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("reset_mid_copy");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_copy hold %0d: done=%b busy=%b expected 0/0", c, done, busy);
            end
        end
        rst_n = 1'b1;
        ref_mem[19'h380] = w0;
        checks++;
        if (mem_rd(19'h380) !== w0 || mem_rd(19'h381) !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_copy ram: got %h/%h expected %h/0", mem_rd(19'h380), mem_rd(19'h381), w0);
        end
        prev_count = 0;
        prev_aborted = 1'b0;
        run_cmd("after_reset", 1'b1, 19'h0, 19'h390, 2, 32'h7777_8888, 4'hF, -1, -1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            logic        m;
            logic [18:0] s, d;
            logic [31:0] f;
            logic [3:0]  be;
            int          n, nat, ab, bs;
            m = 1'($urandom_range(0, 1));
            s = 19'(32'h1000 + $urandom_range(0, 64));
            case ($urandom_range(0, 2))
                0:       d = s + 19'($urandom_range(0, 3));
                1:       d = s - 19'($urandom_range(1, 3));
                default: d = 19'(32'h2000 + $urandom_range(0, 64));
            endcase
            n  = int'($urandom_range(0, 12));
            f  = $urandom;
            be = 4'($urandom);
            for (int k = 0; k < n; k++) preload(s + 19'(k), $urandom);
            nat = (n == 0) ? 1 : (m ? n + 1 : 3 * n + 1);
            ab  = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, nat + 1));
            bs  = ($urandom_range(0, 1) == 0) ? -1 : 1;
            run_cmd("random", m, s, d, n, f, be, ab, bs);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_copy();
        test_fill_mask();
        test_wrap();
        test_len_zero();
        test_abort();
        test_busy_start();
        test_back_to_back();
        test_reset_mid_copy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_dma_engine.md
# ram_dma_engine

Single-port initiator that moves or fills blocks of 32-bit words in the shared dual-port RAM through one of its ports (port A or B, byte-write-enabled, 1-cycle registered read latency). It sits between the control/CSR logic and the RAM, turning one start command into a sequence of RAM read/write cycles. It reports progress, completion and abort status back to the controller.

## Interface

Parameters:
- ADDR_W, 19, word-address width of the RAM port.
- DATA_W, 32, RAM data width; byte enables are DATA_W/8 bits.
- LEN_W, 20, transfer-length width in words (covers 0..2^19).

Ports:
- clk  in  1  single clock; drives the RAM port clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- mode  in  1  0 = copy src→dst, 1 = fill dst with fill_data.
- src_addr  in  ADDR_W  first source word address (copy only).
- dst_addr  in  ADDR_W  first destination word address.
- len  in  LEN_W  number of words to transfer.
- fill_data  in  DATA_W  pattern written in fill mode.
- byte_en  in  DATA_W/8  byte mask applied to every write.
- abort  in  1  request early termination.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of command.
- aborted  out  1  set with done if terminated by abort; held until next start.
- xfer_count  out  LEN_W  words written so far; held after done until next start.
- ram_en  out  1  RAM port enable.
- ram_we  out  DATA_W/8  RAM byte write enables.
- ram_addr  out  ADDR_W  RAM word address.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM read data, valid the cycle after a read is issued.

## Operation

- States: IDLE, READ, CAPTURE, WRITE, DONE.
- All RAM-port outputs are Moore decodes of registered state and registered address/data. There is no combinational path from inputs to RAM-port outputs.
- IDLE: on start, latch mode, src, dst, len, fill_data and byte_en; clear xfer_count and aborted.
  - len==0 → DONE.
  - Otherwise mode 0 → READ, mode 1 → WRITE.
- READ: ram_en=1, ram_we=0, ram_addr=src → CAPTURE.
- CAPTURE: ram_en=0. Capture ram_dout into the hold register at the end of the cycle → WRITE.
- WRITE: ram_en=1, ram_we=byte_en, ram_addr=dst, ram_din=hold (copy) or fill_data (fill).
  - At the end of the cycle, increment xfer_count, src and dst.
  - If xfer_count+1==len → DONE.
  - Otherwise → READ (copy) or stay in WRITE (fill).
- DONE: done=1 for exactly one cycle → IDLE.
- Addresses increment modulo 2^ADDR_W: 0x7FFFF wraps to 0x00000.
- byte_en==0: write cycles are still issued with ram_we=0 and still counted.
- start outside IDLE is ignored; the latched command is not disturbed.
- abort:
  - In READ or CAPTURE: discard the pending word, no write, → DONE with aborted=1.
  - In WRITE: the write in that cycle completes and is counted, then → DONE with aborted=1.
  - In IDLE or DONE: ignored.
  - abort and the last WRITE in the same cycle → DONE with aborted=1 and xfer_count=len.
- Overlapping src/dst ranges are copied in ascending address order with no hazard protection.

## Timing

- Reset values: state=IDLE; busy=0, done=0, aborted=0, xfer_count=0, ram_en=0, ram_we=0, ram_addr=0, ram_din=0.
- Reset is asynchronous mid-command; the transfer is lost and no done pulse is generated.
- Command sampled at cycle 0 (start high in IDLE); busy rises at cycle 1.
- Copy of N words: read k at cycle 3k+1, data captured at cycle 3k+2, write k at cycle 3k+3. done at cycle 3N+1; IDLE at 3N+2.
- Fill of N words: write k at cycle k+1; done at cycle N+1.
- len==0: done at cycle 1, no RAM access.
- A new start is accepted the cycle after done, back-to-back.

## Test plan

- Copy: preload RAM[0x100..0x103]=A0..A3; start mode=0, src=0x100, dst=0x200, len=4, byte_en=0xF → RAM[0x200..0x203]=A0..A3, done at cycle 13, xfer_count=4, aborted=0.
- Fill with partial mask: RAM[0x10..0x17]=0; mode=1, dst=0x10, len=8, fill_data=0xDEADBEEF, byte_en=0x3 → each word 0x0000BEEF, done at cycle 9.
- Wrap: mode=1, dst=0x7FFFE, len=4 → writes to 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
- len=0: start → done at cycle 1; ram_en never asserted; xfer_count=0.
- Abort: copy len=10, assert abort in the CAPTURE cycle of word 3 → 3 words written, no 4th write, done with aborted=1, xfer_count=3. Also assert abort during the final WRITE → xfer_count=len, aborted=1.
- Start while busy, and reset mid-copy: start pulsed during copy does not alter src/dst/len; rst_n low mid-copy → all outputs at reset values immediately, no done pulse.
